sel_mux_pipe: RTL and testbench
===============================

SEL_MUX_PIPE -- requirements
Module: sel_mux_pipe

Interface
REQ-001 Parameter W, default 2: data width per input lane, in bits (W >= 1).
REQ-002 Parameter N, default 3: number of input lanes (N >= 2; a non-power-of-2 value is legal).
REQ-003 Parameter MODE, default 0: invalid-select policy. 0 = zero-fill; 1 = fall-through to lane 0.
REQ-004 Derived SW = max(1, ceil(log2(N))): select width.
REQ-005 clk  in  1: the single clock; all state updates on its rising edge.
REQ-006 rst  in  1: reset, synchronous and active-high.
REQ-007 in_data  in  N*W: packed lanes; lane k occupies bits [k*W +: W].
REQ-008 in_sel  in  SW: lane index.
REQ-009 in_valid  in  1: the input beat is present.
REQ-010 in_ready  out  1: the block can accept the input beat.
REQ-011 out_data  out  W: registered selected lane.
REQ-012 out_valid  out  1: out_data holds an unconsumed beat.
REQ-013 out_ready  in  1: the downstream consumer takes the beat.
REQ-014 out_err  out  1: the beat on out_data came from an invalid select.
REQ-015 err_clr  in  1: clears err_cnt.
REQ-016 err_cnt  out  8: count of accepted invalid selects.

Function
REQ-017 A select is invalid when in_sel >= N; otherwise it is valid.
REQ-018 in_ready SHALL equal (!out_valid || out_ready); this is combinational, and no other combinational path exists from inputs to outputs.
REQ-019 Accept occurs when in_valid && in_ready.
- On accept, the output register loads at the next edge: latency is exactly 1 cycle.
REQ-020 On accept with a valid select: out_data <= lane[in_sel]; out_err <= 0; out_valid <= 1.
REQ-021 On accept with an invalid select:
- MODE=0: out_data <= 0.
- MODE=1: out_data <= lane 0.
- In both modes: out_err <= 1; out_valid <= 1.
REQ-022 When out_valid && out_ready and no accept occurs: out_valid <= 0. out_data and out_err hold their values.
REQ-023 When out_valid && !out_ready (stall), out_data, out_err and out_valid SHALL hold unchanged regardless of in_data, in_sel or in_valid.
REQ-024 A consume and an accept in the same cycle SHALL load the new beat with out_valid staying 1. Back-to-back throughput is 1 beat per clock.
REQ-025 err_cnt increments by 1 on each accept with an invalid select. It saturates at 255 and does not wrap.
REQ-026 err_clr has priority: when err_clr and an invalid accept occur in the same cycle, err_cnt <= 0.
REQ-027 A select of X or Z SHALL never reach out_data as X in MODE=1 (fall-through behaviour). The bench checks this in RTL simulation only.

Reset
REQ-028 While rst is asserted at an edge: out_valid <= 0, out_data <= 0, out_err <= 0, err_cnt <= 0.
REQ-029 rst has priority over an accept, a consume and err_clr in the same cycle; a beat in flight is discarded.
REQ-030 in_ready SHALL read 1 in the first cycle after reset deasserts.

Verification (N=3, W=2, in_data = {lane2=01, lane1=11, lane0=10})
REQ-031 MODE=0, out_ready=1, in_sel=1, single in_valid pulse -> next cycle out_data=11, out_valid=1, out_err=0. One cycle later out_valid=0.
REQ-032 MODE=0, in_sel=3 accepted -> out_data=00, out_err=1, err_cnt=1. With MODE=1 and the same stimulus -> out_data=10, out_err=1.
REQ-033 Accept in_sel=2, then out_ready=0 for 4 cycles while in_sel and in_data toggle -> out_data stays 01 and in_ready=0 throughout. Raise out_ready with in_valid=1 and in_sel=0 -> next cycle out_data=10 with no bubble.
REQ-034 Continuous invalid accepts for 260 cycles -> err_cnt=255. Then err_clr together with an invalid accept -> err_cnt=0.
REQ-035 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=00, err_cnt=0, in_ready=1.
REQ-036 MODE=1, in_sel driven to X then to Z with in_valid=1 -> out_data=10, never X.

Source files
------------

// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe: picks one of N packed lanes by index and presents it through
// a single registered valid/ready output stage. Selects that do not name a
// real lane are flagged on out_err, counted in err_cnt, and replaced by either
// zero or lane 0 depending on MODE.
module sel_mux_pipe #(
  parameter  int W    = 2,
  parameter  int N    = 3,
  parameter  int MODE = 0,
  localparam int SW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_err,
  input  logic           err_clr,
  output logic [7:0]     err_cnt
);

  logic [W-1:0] lane [N];
  logic [W-1:0] pick_data;
  logic         sel_ok;
  logic         accept;

  // Unpack the flat input bus into one entry per lane.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      lane[k] = in_data[k*W +: W];
    end
  end

  // Compare the select against every real lane index; a select that matches
  // none of them (out of range, or unknown in simulation) keeps the
  // invalid-select fill value, so an unknown index can never leak into the data.
  always_comb begin
    sel_ok    = 1'b0;
    pick_data = (MODE == 1) ? lane[0] : '0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SW'(k)) begin
        sel_ok    = 1'b1;
        pick_data = lane[k];
      end
    end
  end

  // The stage can take a beat when it is empty or its beat leaves this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register: load on accept, drain on consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= pick_data;
      out_err   <= !sel_ok;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of accepted invalid selects; a clear beats an increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (accept && !sel_ok && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sel_mux_pipe.sv
// tb_sel_mux_pipe: drives one MODE=0 and one MODE=1 instance with identical
// stimulus and checks both against directed expectations and a beat-level model.
module tb_sel_mux_pipe;
  localparam int W  = 2;
  localparam int N  = 3;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [SW-1:0]  in_sel;
  logic           in_valid;
  logic           out_ready;
  logic           err_clr;
  logic           rdy0, rdy1, ov0, ov1, oe0, oe1;
  logic [W-1:0]   od0, od1;
  logic [7:0]     ec0, ec1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sel_mux_pipe #(.W(W), .N(N), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(rdy0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
    .out_err(oe0), .err_clr(err_clr), .err_cnt(ec0)
  );

  sel_mux_pipe #(.W(W), .N(N), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(rdy1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
    .out_err(oe1), .err_clr(err_clr), .err_cnt(ec1)
  );

  // Reference lanes: lane2=01, lane1=11, lane0=10
  localparam logic [N*W-1:0] REF_DATA = {2'b01, 2'b11, 2'b10};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    in_sel    = '0;
    in_data   = REF_DATA;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (ov0 !== 1'b0 || ov1 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b/%b want 0/0", ov0, ov1); end
    n_checks++; if (od0 !== 2'b00 || od1 !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_data: got %b/%b want 00/00", od0, od1); end
    n_checks++; if (oe0 !== 1'b0 || oe1 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b/%b want 0/0", oe0, oe1); end
    n_checks++; if (ec0 !== 8'd0 || ec1 !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d/%0d want 0/0", ec0, ec1); end
    n_checks++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b/%b want 1/1", rdy0, rdy1); end
  endtask

  task automatic test_single();
    in_data = REF_DATA; in_sel = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++; if (od0 !== 2'b11 || od1 !== 2'b11) begin n_fail++; $display("[TB] FAIL single_data: got %b/%b want 11/11", od0, od1); end
    n_checks++; if (ov0 !== 1'b1 || ov1 !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid: got %b/%b want 1/1", ov0, ov1); end
    n_checks++; if (oe0 !== 1'b0 || oe1 !== 1'b0) begin n_fail++; $display("[TB] FAIL single_err: got %b/%b want 0/0", oe0, oe1); end
    step();
    n_checks++; if (ov0 !== 1'b0 || ov1 !== 1'b0) begin n_fail++; $display("[TB] FAIL single_drain: got %b/%b want 0/0", ov0, ov1); end
  endtask

  task automatic test_invalid();
    in_data = REF_DATA; in_sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++; if (od0 !== 2'b00) begin n_fail++; $display("[TB] FAIL invalid_data_mode0: got %b want 00", od0); end
    n_checks++; if (od1 !== 2'b10) begin n_fail++; $display("[TB] FAIL invalid_data_mode1: got %b want 10", od1); end
    n_checks++; if (oe0 !== 1'b1 || oe1 !== 1'b1) begin n_fail++; $display("[TB] FAIL invalid_err: got %b/%b want 1/1", oe0, oe1); end
    n_checks++; if (ec0 !== 8'd1 || ec1 !== 8'd1) begin n_fail++; $display("[TB] FAIL invalid_cnt: got %0d/%0d want 1/1", ec0, ec1); end
    step();
  endtask

  task automatic test_stall();
    in_data = REF_DATA; in_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_sel  = SW'(3 - i);
      in_data = (N*W)'($urandom());
      #1;
      n_checks++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_ready[%0d]: got %b/%b want 0/0", i, rdy0, rdy1); end
      step();
      n_checks++; if (od0 !== 2'b01 || od1 !== 2'b01) begin n_fail++; $display("[TB] FAIL stall_data[%0d]: got %b/%b want 01/01", i, od0, od1); end
      n_checks++; if (ov0 !== 1'b1 || ov1 !== 1'b1 || oe0 !== 1'b0 || oe1 !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_flags[%0d]: got v%b%b e%b%b want v11 e00", i, ov0, ov1, oe0, oe1); end
    end
    n_checks++; if (ec0 !== 8'd1 || ec1 !== 8'd1) begin n_fail++; $display("[TB] FAIL stall_cnt: got %0d/%0d want 1/1", ec0, ec1); end
    in_data = REF_DATA; in_sel = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin n_fail++; $display("[TB] FAIL release_ready: got %b/%b want 1/1", rdy0, rdy1); end
    step();
    in_valid = 1'b0;
    n_checks++; if (od0 !== 2'b10 || od1 !== 2'b10 || ov0 !== 1'b1 || ov1 !== 1'b1) begin n_fail++; $display("[TB] FAIL back_to_back: got d%b/%b v%b%b want d10/10 v11", od0, od1, ov0, ov1); end
    step();
  endtask

  task automatic test_saturate();
    do_reset();
    in_data = REF_DATA; in_sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 255; i++) step();
    n_checks++; if (ec0 !== 8'd255 || ec1 !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_reach: got %0d/%0d want 255/255", ec0, ec1); end
    for (int i = 0; i < 5; i++) step();
    n_checks++; if (ec0 !== 8'd255 || ec1 !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_hold: got %0d/%0d want 255/255", ec0, ec1); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0; in_valid = 1'b0;
    n_checks++; if (ec0 !== 8'd0 || ec1 !== 8'd0) begin n_fail++; $display("[TB] FAIL clr_priority: got %0d/%0d want 0/0", ec0, ec1); end
    n_checks++; if (oe0 !== 1'b1 || oe1 !== 1'b1) begin n_fail++; $display("[TB] FAIL clr_beat_err: got %b/%b want 1/1", oe0, oe1); end
    step();
  endtask

  task automatic test_reset_priority();
    in_data = REF_DATA; in_sel = 2'd3; in_valid = 1'b1; out_ready = 1'b0;
    step();
    n_checks++; if (ec0 !== 8'd1 || ov0 !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_rst: got cnt %0d v%b want cnt 1 v1", ec0, ov0); end
    in_sel = 2'd1; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (ov0 !== 1'b0 || ov1 !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %b/%b want 0/0", ov0, ov1); end
    n_checks++; if (od0 !== 2'b00 || od1 !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_data: got %b/%b want 00/00", od0, od1); end
    n_checks++; if (ec0 !== 8'd0 || ec1 !== 8'd0) begin n_fail++; $display("[TB] FAIL rst_cnt: got %0d/%0d want 0/0", ec0, ec1); end
    #1;
    n_checks++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_ready: got %b/%b want 1/1", rdy0, rdy1); end
    out_ready = 1'b1;
  endtask

  task automatic test_x_select();
    do_reset();
    in_data = REF_DATA; in_valid = 1'b1; out_ready = 1'b1;
    in_sel = 'x;
    step();
    n_checks++; if (od1 !== 2'b10) begin n_fail++; $display("[TB] FAIL xsel_data: got %b want 10", od1); end
    in_sel = 'z;
    step();
    n_checks++; if (od1 !== 2'b10) begin n_fail++; $display("[TB] FAIL zsel_data: got %b want 10", od1); end
    do_reset();
  endtask

  function automatic int lane_of(logic [N*W-1:0] d, int idx);
    return int'((d >> (idx * W)) & ((N*W)'(3)));
  endfunction

  task automatic test_random();
    int mv [2];
    int md [2];
    int me [2];
    int mc [2];
    do_reset();
    for (int m = 0; m < 2; m++) begin mv[m] = 0; md[m] = 0; me[m] = 0; mc[m] = 0; end
    for (int c = 0; c < 400; c++) begin
      int  sel;
      bit  bad;
      bit  acc;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 19) == 0);
      sel       = int'($urandom_range(0, 3));
      in_sel    = SW'(sel);
      in_data   = (N*W)'($urandom());
      #1;
      n_checks++; if (rdy0 !== (mv[0] == 0 || out_ready) || rdy1 !== (mv[1] == 0 || out_ready)) begin n_fail++; $display("[TB] FAIL rand_ready[%0d]: got %b/%b model v%0d/%0d or%b", c, rdy0, rdy1, mv[0], mv[1], out_ready); end
      bad = (sel >= N);
      for (int m = 0; m < 2; m++) begin
        acc = in_valid && (mv[m] == 0 || out_ready);
        if (acc) begin
          mv[m] = 1;
          me[m] = bad ? 1 : 0;
          md[m] = bad ? ((m == 1) ? lane_of(in_data, 0) : 0) : lane_of(in_data, sel);
        end else if (out_ready) begin
          mv[m] = 0;
        end
        if (err_clr) mc[m] = 0;
        else if (acc && bad && mc[m] < 255) mc[m] = mc[m] + 1;
      end
      step();
      n_checks++; if (int'(ov0) != mv[0] || int'(od0) != md[0] || int'(oe0) != me[0] || int'(ec0) != mc[0]) begin n_fail++; $display("[TB] FAIL rand_mode0[%0d]: got v%b d%b e%b c%0d want v%0d d%0d e%0d c%0d", c, ov0, od0, oe0, ec0, mv[0], md[0], me[0], mc[0]); end
      n_checks++; if (int'(ov1) != mv[1] || int'(od1) != md[1] || int'(oe1) != me[1] || int'(ec1) != mc[1]) begin n_fail++; $display("[TB] FAIL rand_mode1[%0d]: got v%b d%b e%b c%0d want v%0d d%0d e%0d c%0d", c, ov1, od1, oe1, ec1, mv[1], md[1], me[1], mc[1]); end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_invalid();
    test_stall();
    test_saturate();
    test_reset_priority();
    test_x_select();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
